mips_rf_sequencer: RTL and testbench
====================================

# mips_rf_sequencer

Clocked register-file and write-back sequencer that drives the MIPS core datapath. Accepts one 32-bit instruction per handshake, decodes the rs/rt/rd fields, presents register operands and the instruction to the core ALU, waits for the result, and writes it back to rd (R-type) or rt (I-type). Register 0 is hardwired to zero. This block replaces file-based register handling in the core test flow with synthesizable, parametrised state.

## Interface
Parameters:
- DATA_W, 32, register and operand width; must be ≥ 16
- ADDR_W, 5, register index width; REG_COUNT = 2**ADDR_W; instruction fields are truncated or zero-extended to ADDR_W

Ports (clock and reset: one clock, synchronous active-high reset):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  32  MIPS instruction word
- alu_start  out  1  one-cycle pulse: operands valid
- alu_instr  out  32  latched instruction
- alu_a  out  DATA_W  rs contents
- alu_b  out  DATA_W  rt contents
- alu_imm  out  DATA_W  sign-extended instr[15:0]
- alu_done  in  1  ALU result valid
- alu_result  in  DATA_W  ALU result
- wb_valid  out  1  one-cycle pulse: write-back performed
- wb_addr  out  ADDR_W  destination register
- wb_data  out  DATA_W  value written
- init_we  in  1  preload write strobe; honoured only in IDLE
- init_addr  in  ADDR_W  preload index
- init_data  in  DATA_W  preload value
- dbg_addr  in  ADDR_W  debug read index
- dbg_data  out  DATA_W  debug read data (combinational)

## Operation
- Field decode: opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11].
- Destination: rd if opcode == 0, otherwise rt.
- FSM states are IDLE, READ, EXEC, and WB.
  - IDLE: instr_ready = 1. On instr_valid, latch instr and go to READ. If init_we is also asserted in the same cycle, the preload write happens and the instruction is still accepted.
  - READ: register alu_a = R[rs], alu_b = R[rt], and alu_imm. Pulse alu_start. Go to EXEC.
  - EXEC: hold the operands. On alu_done, latch alu_result and go to WB. alu_done is ignored in every other state.
  - WB: write R[dest] = result unless dest == 0. Pulse wb_valid, with wb_addr = dest and wb_data = result. wb_data reports the ALU value even when dest == 0. Go to IDLE.
- Reads of index 0 always return 0. Writes to 0, whether from init or write-back, are discarded.
- init_we outside IDLE is ignored.
- Reset clears all registers and outputs to 0, sets the state to IDLE, and sets instr_ready to 1 from the first cycle after reset. Reset asserted mid-instruction aborts the instruction with no write-back.

## Timing
- Accept at edge N. alu_start is high in cycle N+1. The earliest alu_done is sampled at edge N+2. The register write and wb_valid land one cycle after the alu_done edge. The minimum accept-to-accept interval is 4 cycles.
- instr_ready is low from the cycle after acceptance until WB completes. It is high again in the cycle following WB.
- alu_a, alu_b, alu_imm, and alu_instr are stable from alu_start until the next acceptance.
- dbg_data is a combinational read of the register array.

## Configuration
- MIPS_RF_BYPASS_EN is defined:
  - dbg_data returns wb_data when dbg_addr equals the register being written in WB (nonzero).
  - The same applies to the init_data being written in IDLE.
- MIPS_RF_BYPASS_EN is undefined: dbg_data returns the pre-write contents during the write cycle. The new value becomes visible on the next cycle.

## Test plan
- Reset, then read all dbg_addr values: expect 0 everywhere, instr_ready = 1, and alu_start = wb_valid = 0.
- Preload R[5]=0x0000000A and R[11]=0x00000003. Issue 0x00AB6020 (R-type, rs=5, rt=11, rd=12). Return alu_result = 0x0000000D two cycles after alu_start. Expect alu_a = 0xA, alu_b = 0x3, wb_addr = 12, and R[12] = 0xD.
- Issue I-type 0x2085FFFF (rs=4, rt=5, imm=0xFFFF). Expect alu_imm = 0xFFFFFFFF, and the write lands in R[5], not rd.
- Issue R-type with rd=0 and alu_result = 0x12345678: wb_valid pulses, and R[0] still reads 0.
- Assert rst while in EXEC: the sequencer returns to IDLE, no wb_valid pulse occurs, and all registers are 0.
- With MIPS_RF_BYPASS_EN, set dbg_addr = 12 during WB of the second scenario: dbg_data = 0xD in that cycle. Without the macro: 0 in that cycle, 0xD one cycle later.

Source files
------------

// File: rtl/mips_rf_sequencer.sv
// Register file plus accept/read/execute/write-back sequencer for the MIPS core ALU.
// Optional MIPS_RF_BYPASS_EN: dbg_data forwards the value being written in the same cycle.
module mips_rf_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              alu_start,
  output logic [31:0]       alu_instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_imm,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int REG_COUNT = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] a_q, b_q, imm_q, result_q;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [ADDR_W-1:0] rs_idx, rt_idx, dest;
  logic              accept, init_write;

  function automatic logic [ADDR_W-1:0] to_idx(input logic [4:0] field);
    return ADDR_W'(field);
  endfunction

  assign accept     = (state == IDLE) && instr_valid;
  assign init_write = (state == IDLE) && init_we && (init_addr != '0);
  assign rs_idx     = to_idx(instr[25:21]);
  assign rt_idx     = to_idx(instr[20:16]);
  assign dest       = (instr_q[31:26] == 6'd0) ? to_idx(instr_q[15:11]) : to_idx(instr_q[20:16]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (instr_valid) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    if (alu_done) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    alu_start   = (state == READ);
    wb_valid    = (state == WB);
  end

  // Operand fetch sees a preload to the same register landing at the accept edge.
  always_comb begin
    rs_val = regs[rs_idx];
    rt_val = regs[rt_idx];
    if (init_write && (init_addr == rs_idx)) rs_val = init_data;
    if (init_write && (init_addr == rt_idx)) rt_val = init_data;
    if (rs_idx == '0) rs_val = '0;
    if (rt_idx == '0) rt_val = '0;
  end

  // Operands are captured at the accept edge so they are already valid while alu_start is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      result_q <= '0;
    end else begin
      if (init_write) regs[init_addr] <= init_data;
      if ((state == WB) && (dest != '0)) regs[dest] <= result_q;
      if (accept) begin
        instr_q <= instr;
        a_q     <= rs_val;
        b_q     <= rt_val;
        imm_q   <= DATA_W'($signed(instr[15:0]));
      end
      if ((state == EXEC) && alu_done) result_q <= alu_result;
    end
  end

  assign alu_instr = instr_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_imm   = imm_q;
  assign wb_addr   = dest;
  assign wb_data   = result_q;

  always_comb begin
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
`ifdef MIPS_RF_BYPASS_EN
    if ((state == WB) && (dest != '0) && (dbg_addr == dest))
      dbg_data = result_q;
    else if (init_write && (dbg_addr == init_addr))
      dbg_data = init_data;
`endif
  end

endmodule

// File: tb/tb_mips_rf_sequencer.sv
// Directed self-checking bench for mips_rf_sequencer with hand-computed expectations.
module tb_mips_rf_sequencer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic              alu_start;
  logic [31:0]       alu_instr;
  logic [DATA_W-1:0] alu_a, alu_b, alu_imm;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  int errors = 0;
  int checks = 0;

  mips_rf_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_start(alu_start), .alu_instr(alu_instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
    .alu_done(alu_done), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < 2**ADDR_W; i++) begin
      dbg_addr = ADDR_W'(i);
      #1;
      checkOutput(tag, dbg_data, 32'h0);
    end
  endtask

  // One full instruction; alu_done rises waitCycles cycles after alu_start.
  task automatic applyStimulus(input logic [31:0] word, input logic [31:0] res, input int waitCycles,
                               input logic [31:0] expA, input logic [31:0] expB, input logic [31:0] expImm,
                               input logic [4:0] expDest, input logic [31:0] oldDest);
    logic [31:0] want;
    checkOutput("ready_idle", 32'(instr_ready), 32'h1);
    instr       = word;
    instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
    checkOutput("alu_start", 32'(alu_start), 32'h1);
    checkOutput("ready_busy", 32'(instr_ready), 32'h0);
    checkOutput("alu_a", alu_a, expA);
    checkOutput("alu_b", alu_b, expB);
    checkOutput("alu_imm", alu_imm, expImm);
    checkOutput("alu_instr", alu_instr, word);
    alu_done   = 1'b1;
    alu_result = 32'hDEAD_BEEF;
    init_we    = 1'b1;
    init_addr  = 5'd20;
    init_data  = 32'h5555_5555;
    for (int k = 0; k < waitCycles; k++) begin
      tick;
      alu_done = 1'b0;
      checkOutput("start_pulse", 32'(alu_start), 32'h0);
      checkOutput("no_early_wb", 32'(wb_valid), 32'h0);
      checkOutput("hold_a", alu_a, expA);
      checkOutput("hold_b", alu_b, expB);
    end
    alu_done   = 1'b1;
    alu_result = res;
    tick;
    alu_done = 1'b0;
    checkOutput("wb_valid", 32'(wb_valid), 32'h1);
    checkOutput("wb_addr", 32'(wb_addr), 32'(expDest));
    checkOutput("wb_data", wb_data, res);
    dbg_addr = expDest;
    #1;
`ifdef MIPS_RF_BYPASS_EN
    want = (expDest != 5'd0) ? res : 32'h0;
`else
    want = oldDest;
`endif
    checkOutput("dbg_in_wb", dbg_data, want);
    tick;
    init_we = 1'b0;
    checkOutput("wb_pulse_end", 32'(wb_valid), 32'h0);
    checkOutput("ready_again", 32'(instr_ready), 32'h1);
    checkOutput("dbg_after_wb", dbg_data, (expDest != 5'd0) ? res : 32'h0);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; alu_done = 1'b0; alu_result = '0;
    init_we = 1'b0; init_addr = '0; init_data = '0; dbg_addr = '0;
    tick;
    tick;
    rst = 1'b0;
    checkOutput("rst_ready", 32'(instr_ready), 32'h1);
    checkOutput("rst_start", 32'(alu_start), 32'h0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'h0);
    checkOutput("rst_wb_data", wb_data, 32'h0);
    checkOutput("rst_alu_a", alu_a, 32'h0);
    checkAllZero("rst_regs");

    // Preload R5 and R11
    init_we = 1'b1; init_addr = 5'd5; init_data = 32'h0000_000A; dbg_addr = 5'd5;
    #1;
`ifdef MIPS_RF_BYPASS_EN
    checkOutput("init_bypass", dbg_data, 32'h0000_000A);
`else
    checkOutput("init_bypass", dbg_data, 32'h0);
`endif
    tick;
    init_addr = 5'd11; init_data = 32'h0000_0003;
    tick;
    init_we = 1'b0;
    dbg_addr = 5'd5;  #1; checkOutput("pre_r5", dbg_data, 32'h0000_000A);
    dbg_addr = 5'd11; #1; checkOutput("pre_r11", dbg_data, 32'h0000_0003);

    applyStimulus(32'h00AB6020, 32'h0000_000D, 2, 32'hA, 32'h3, 32'h0000_6020, 5'd12, 32'h0);
    applyStimulus(32'h2085FFFF, 32'h0000_0009, 1, 32'h0, 32'hA, 32'hFFFF_FFFF, 5'd5, 32'hA);
    dbg_addr = 5'd31; #1; checkOutput("itype_not_rd", dbg_data, 32'h0);
    applyStimulus(32'h01850020, 32'h1234_5678, 1, 32'hD, 32'h9, 32'h0000_0020, 5'd0, 32'h0);
    dbg_addr = 5'd0;  #1; checkOutput("r0_zero", dbg_data, 32'h0);
    dbg_addr = 5'd20; #1; checkOutput("init_busy_ignored", dbg_data, 32'h0);

    // Preload and accept in the same cycle
    init_we = 1'b1; init_addr = 5'd3; init_data = 32'h0000_0077;
    applyStimulus(32'h00002020, 32'h0000_0005, 1, 32'h0, 32'h0, 32'h0000_2020, 5'd4, 32'h0);
    dbg_addr = 5'd3; #1; checkOutput("init_with_accept", dbg_data, 32'h0000_0077);

    // Reset while in EXEC aborts the instruction
    instr = 32'h00AB6020; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    tick;
    checkOutput("exec_busy", 32'(instr_ready), 32'h0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkOutput("abort_ready", 32'(instr_ready), 32'h1);
    checkOutput("abort_no_wb", 32'(wb_valid), 32'h0);
    checkOutput("abort_alu_a", alu_a, 32'h0);
    checkOutput("abort_wb_data", wb_data, 32'h0);
    tick;
    checkOutput("abort_no_wb2", 32'(wb_valid), 32'h0);
    checkAllZero("abort_regs");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
